serial_subtractor: RTL

- Bit-serial subtractor: computes a - b for two WIDTH-bit operands streamed LSB-first, one bit pair per accepted cycle.
- Emits a registered serial difference stream and, at end of frame, a parallel result word with borrow, signed-overflow and zero flags.
- Acts as the inverse-operation companion to the serial adder, sharing its LSB-first serial operand format, and sits in the same bit-serial arithmetic datapath.

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b over WIDTH-bit operands streamed LSB-first.
// Produces a registered serial difference stream and, at the end of each
// frame, a parallel result word with borrow, signed-overflow and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             bit_valid,
  output logic             diff,
  output logic             diff_valid,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             diff_q, diff_d;
  logic             diff_valid_q, diff_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  // Full-subtractor cell and the shift value it would produce this cycle.
  logic             d_bit, borrow_nx, last_bit;
  logic [WIDTH-1:0] sr_nx;

  // Next-state logic: frame control, serial datapath and end-of-frame publish.
  always_comb begin
    d_bit     = a ^ b ^ borrow_q;
    borrow_nx = (~a & b) | (~(a ^ b) & borrow_q);
    sr_nx     = {d_bit, sr_q[WIDTH-1:1]};
    last_bit  = (cnt_q == CW'(WIDTH - 1));

    state_d      = state_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    diff_d       = diff_q;
    diff_valid_d = 1'b0;
    result_d     = result_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A bit presented alongside start is deliberately not consumed.
        if (start) begin
          state_d  = S_RUN;
          borrow_d = 1'b0;
          cnt_d    = '0;
          sr_d     = '0;
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          diff_d       = d_bit;
          diff_valid_d = 1'b1;
          borrow_d     = borrow_nx;
          cnt_d        = cnt_q + CW'(1);
          sr_d         = sr_nx;
          if (last_bit) begin
            // MSB cell: a, b and d_bit are the sign bits of the operands/result.
            result_d     = sr_nx;
            borrow_out_d = borrow_nx;
            zero_d       = (sr_nx == '0);
            overflow_d   = (a != b) && (d_bit != a);
            done_d       = 1'b1;
            cnt_d        = '0;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      sr_q         <= '0;
      diff_q       <= 1'b0;
      diff_valid_q <= 1'b0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      diff_q       <= diff_d;
      diff_valid_q <= diff_valid_d;
      result_q     <= result_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
      zero_q       <= zero_d;
      done_q       <= done_d;
    end
  end

  assign diff       = diff_q;
  assign diff_valid = diff_valid_q;
  assign result     = result_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule
